// File: rtl/reg_debug_port_pkg.sv
// Shared widths, opcodes and FSM encoding for the debug-side register file initiator.
// ADDR_W/DATA_W are the same defaults the 16x16 register file uses.
package reg_debug_port_pkg;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 16;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_DUMP  = 2'd2;
    localparam logic [1:0] OP_FILL  = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        FILL = 3'd3,
        RSP  = 3'd4
    } state_t;

endpackage

// File: rtl/reg_debug_port_if.sv
// Command, response and register-file port bundle of the debug port.
// slave = the debug port itself, master = host plus register file side.
interface reg_debug_port_if;
    import reg_debug_port_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [ADDR_W-1:0] rsp_addr;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;

    logic [ADDR_W-1:0] rf_read_reg;
    logic [DATA_W-1:0] rf_read_data;
    logic              rf_write_en;
    logic [ADDR_W-1:0] rf_write_reg;
    logic [DATA_W-1:0] rf_write_data;
    logic              core_hold;

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready, rf_read_data,
        output cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last,
               rf_read_reg, rf_write_en, rf_write_reg, rf_write_data, core_hold
    );

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready, rf_read_data,
        input  cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last,
               rf_read_reg, rf_write_en, rf_write_reg, rf_write_data, core_hold
    );

endinterface

// File: rtl/reg_debug_port.sv
// Debug initiator: runs READ/WRITE/DUMP/FILL against the register file and
// returns results over a valid/ready response channel, holding the core while busy.
module reg_debug_port
    import reg_debug_port_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    reg_debug_port_if.slave  dbg
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic [1:0]        op_reg, op_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic [ADDR_W-1:0] rsp_addr_reg, rsp_addr_next;
    logic [DATA_W-1:0] rsp_data_reg, rsp_data_next;
    logic              rsp_last_reg, rsp_last_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            op_reg       <= '0;
            data_reg     <= '0;
            rsp_addr_reg <= '0;
            rsp_data_reg <= '0;
            rsp_last_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            op_reg       <= op_next;
            data_reg     <= data_next;
            rsp_addr_reg <= rsp_addr_next;
            rsp_data_reg <= rsp_data_next;
            rsp_last_reg <= rsp_last_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        op_next       = op_reg;
        data_next     = data_reg;
        rsp_addr_next = rsp_addr_reg;
        rsp_data_next = rsp_data_reg;
        rsp_last_next = rsp_last_reg;

        case (state_reg)
            IDLE: begin
                if (dbg.cmd_valid) begin
                    op_next   = dbg.cmd_op;
                    data_next = dbg.cmd_data;
                    // Single-register ops target cmd_addr; sweeps always start at 0
                    ptr_next  = (dbg.cmd_op == OP_READ || dbg.cmd_op == OP_WRITE)
                                ? dbg.cmd_addr : '0;
                    case (dbg.cmd_op)
                        OP_WRITE: state_next = WR;
                        OP_FILL:  state_next = FILL;
                        default:  state_next = RD;
                    endcase
                end
            end
            RD: begin
                rsp_data_next = dbg.rf_read_data;
                rsp_addr_next = ptr_reg;
                rsp_last_next = (op_reg == OP_READ) || (ptr_reg == LAST_REG);
                state_next    = RSP;
            end
            WR: begin
                rsp_data_next = data_reg;
                rsp_addr_next = ptr_reg;
                rsp_last_next = 1'b1;
                state_next    = RSP;
            end
            FILL: begin
                if (ptr_reg == LAST_REG) begin
                    rsp_data_next = data_reg;
                    rsp_addr_next = LAST_REG;
                    rsp_last_next = 1'b1;
                    state_next    = RSP;
                end else begin
                    ptr_next = ptr_reg + ADDR_W'(1);
                end
            end
            RSP: begin
                if (dbg.rsp_ready) begin
                    if (rsp_last_reg) begin
                        state_next = IDLE;
                    end else begin
                        // Only DUMP produces non-final responses
                        ptr_next   = ptr_reg + ADDR_W'(1);
                        state_next = RD;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign dbg.cmd_ready     = (state_reg == IDLE);
    assign dbg.core_hold     = (state_reg != IDLE);
    assign dbg.rsp_valid     = (state_reg == RSP);
    assign dbg.rsp_addr      = rsp_addr_reg;
    assign dbg.rsp_data      = rsp_data_reg;
    assign dbg.rsp_last      = rsp_last_reg;
    assign dbg.rf_read_reg   = ptr_reg;
    assign dbg.rf_write_reg  = ptr_reg;
    assign dbg.rf_write_data = data_reg;
    assign dbg.rf_write_en   = (state_reg == WR) || (state_reg == FILL);

endmodule

// File: tb/tb_reg_debug_port.sv
// Directed bench for reg_debug_port with a behavioural 16x16 register file attached.
module tb_reg_debug_port;
    import reg_debug_port_pkg::*;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    int   write_count;
    int   accept_count;

    reg_debug_port_if dbg();

    reg_debug_port dut (
        .clk     (clk),
        .reset_n (reset_n),
        .dbg     (dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] rf_mem [16];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= '0;
        end else if (dbg.rf_write_en) begin
            rf_mem[dbg.rf_write_reg] <= dbg.rf_write_data;
        end
    end

    assign dbg.rf_read_data = rf_mem[dbg.rf_read_reg];

    always @(posedge clk) begin
        if (dbg.rf_write_en) write_count <= write_count + 1;
        if (dbg.cmd_valid && dbg.cmd_ready) accept_count <= accept_count + 1;
    end

    task automatic send_cmd(input logic [1:0] op, input logic [3:0] addr, input logic [15:0] data);
        bit done = 0;
        dbg.cmd_op    = op;
        dbg.cmd_addr  = addr;
        dbg.cmd_data  = data;
        dbg.cmd_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            if (dbg.cmd_ready) done = 1;
            @(posedge clk); #1;
        end
        dbg.cmd_valid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL send_cmd_timeout: cmd_ready=%0b required 1", dbg.cmd_ready);
        end
    endtask

    task automatic wait_rsp(output logic [3:0] a, output logic [15:0] d, output logic l);
        bit got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            if (dbg.rsp_valid) got = 1;
            else begin @(posedge clk); #1; end
        end
        a = dbg.rsp_addr; d = dbg.rsp_data; l = dbg.rsp_last;
        if (!got) begin
            checks++; errors++;
            $display("FAIL wait_rsp_timeout: rsp_valid=%0b required 1", dbg.rsp_valid);
        end
    endtask

    task automatic consume();
        $display("rsp addr=%0d data=%h last=%0b", dbg.rsp_addr, dbg.rsp_data, dbg.rsp_last);
        dbg.rsp_ready = 1'b1;
        @(posedge clk); #1;
        dbg.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (dbg.cmd_ready !== 1'b1 || dbg.rsp_valid !== 1'b0 || dbg.rf_write_en !== 1'b0 ||
            dbg.core_hold !== 1'b0 || dbg.rf_read_reg !== 4'd0 || dbg.rsp_data !== 16'h0000 ||
            dbg.rsp_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%0b valid=%0b wen=%0b hold=%0b rreg=%0d data=%h last=%0b required 1 0 0 0 0 0000 0",
                     dbg.cmd_ready, dbg.rsp_valid, dbg.rf_write_en, dbg.core_hold,
                     dbg.rf_read_reg, dbg.rsp_data, dbg.rsp_last);
        end
    endtask

    task automatic test_write_read();
        int wc0;
        wc0 = write_count;
        dbg.rsp_ready = 1'b0;
        send_cmd(OP_WRITE, 4'd3, 16'hBEEF);
        checks++;
        if (dbg.rf_write_en !== 1'b1 || dbg.rf_write_reg !== 4'd3 || dbg.rf_write_data !== 16'hBEEF || dbg.core_hold !== 1'b1) begin
            errors++;
            $display("FAIL wr_pulse: wen=%0b reg=%0d data=%h hold=%0b required 1 3 beef 1",
                     dbg.rf_write_en, dbg.rf_write_reg, dbg.rf_write_data, dbg.core_hold);
        end
        @(posedge clk); #1;
        checks++;
        if (dbg.rf_write_en !== 1'b0 || dbg.rsp_valid !== 1'b1 || dbg.rsp_addr !== 4'd3 ||
            dbg.rsp_data !== 16'hBEEF || dbg.rsp_last !== 1'b1) begin
            errors++;
            $display("FAIL wr_rsp: wen=%0b valid=%0b addr=%0d data=%h last=%0b required 0 1 3 beef 1",
                     dbg.rf_write_en, dbg.rsp_valid, dbg.rsp_addr, dbg.rsp_data, dbg.rsp_last);
        end
        consume();
        checks++;
        if (write_count - wc0 != 1 || rf_mem[3] !== 16'hBEEF) begin
            errors++;
            $display("FAIL wr_count: pulses=%0d reg3=%h required 1 beef", write_count - wc0, rf_mem[3]);
        end
        send_cmd(OP_READ, 4'd3, 16'h0000);
        checks++;
        if (dbg.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_latency_early: rsp_valid=%0b required 0", dbg.rsp_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (dbg.rsp_valid !== 1'b1 || dbg.rsp_addr !== 4'd3 || dbg.rsp_data !== 16'hBEEF || dbg.rsp_last !== 1'b1) begin
            errors++;
            $display("FAIL rd_rsp: valid=%0b addr=%0d data=%h last=%0b required 1 3 beef 1",
                     dbg.rsp_valid, dbg.rsp_addr, dbg.rsp_data, dbg.rsp_last);
        end
        consume();
        checks++;
        if (dbg.cmd_ready !== 1'b1 || dbg.core_hold !== 1'b0 || write_count - wc0 != 1) begin
            errors++;
            $display("FAIL rd_return_idle: ready=%0b hold=%0b pulses=%0d required 1 0 1",
                     dbg.cmd_ready, dbg.core_hold, write_count - wc0);
        end
    endtask

    task automatic test_fill_dump();
        int wc0;
        int idx;
        int bad;
        bit done;
        logic [3:0]  a;
        logic [15:0] d;
        logic        l;
        wc0 = write_count;
        dbg.rsp_ready = 1'b0;
        send_cmd(OP_FILL, 4'd6, 16'h00A5);
        wait_rsp(a, d, l);
        checks++;
        if (write_count - wc0 != 16 || a !== 4'd15 || d !== 16'h00A5 || l !== 1'b1) begin
            errors++;
            $display("FAIL fill_rsp: pulses=%0d addr=%0d data=%h last=%0b required 16 15 00a5 1",
                     write_count - wc0, a, d, l);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) if (rf_mem[i] !== 16'h00A5) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL fill_contents: wrong_regs=%0d required 0", bad);
        end
        consume();
        wc0 = write_count;
        idx = 0;
        done = 0;
        dbg.rsp_ready = 1'b1;
        send_cmd(OP_DUMP, 4'd9, 16'h0000);
        for (int c = 0; c < 100 && !done; c++) begin
            if (dbg.rsp_valid) begin
                $display("dump addr=%0d data=%h last=%0b", dbg.rsp_addr, dbg.rsp_data, dbg.rsp_last);
                checks++;
                if (dbg.rsp_addr !== 4'(idx) || dbg.rsp_data !== 16'h00A5 || dbg.rsp_last !== (idx == 15)) begin
                    errors++;
                    $display("FAIL dump_rsp: addr=%0d data=%h last=%0b required %0d 00a5 %0b",
                             dbg.rsp_addr, dbg.rsp_data, dbg.rsp_last, idx, (idx == 15));
                end
                if (dbg.rsp_last) done = 1;
                idx++;
            end
            @(posedge clk); #1;
        end
        dbg.rsp_ready = 1'b0;
        checks++;
        if (idx != 16 || !done || write_count != wc0) begin
            errors++;
            $display("FAIL dump_count: responses=%0d last_seen=%0b pulses=%0d required 16 1 0",
                     idx, done, write_count - wc0);
        end
    endtask

    task automatic test_stall();
        int wc0;
        bit seen7;
        bit done;
        logic [3:0]  a;
        logic [15:0] d;
        logic        l;
        dbg.rsp_ready = 1'b0;
        send_cmd(OP_WRITE, 4'd7, 16'h7777);
        wait_rsp(a, d, l);
        consume();
        wc0 = write_count;
        seen7 = 0;
        done = 0;
        send_cmd(OP_DUMP, 4'd0, 16'h0000);
        for (int n = 0; n < 16 && !done; n++) begin
            wait_rsp(a, d, l);
            if (a == 4'd7) begin
                seen7 = 1;
                for (int k = 0; k < 10; k++) begin
                    @(posedge clk); #1;
                    checks++;
                    if (dbg.rsp_valid !== 1'b1 || dbg.rsp_addr !== 4'd7 || dbg.rsp_data !== 16'h7777 ||
                        dbg.rsp_last !== 1'b0 || dbg.rf_read_reg !== 4'd7) begin
                        errors++;
                        $display("FAIL stall_hold: valid=%0b addr=%0d data=%h last=%0b ptr=%0d required 1 7 7777 0 7",
                                 dbg.rsp_valid, dbg.rsp_addr, dbg.rsp_data, dbg.rsp_last, dbg.rf_read_reg);
                    end
                end
            end
            consume();
            if (l) done = 1;
        end
        checks++;
        if (!seen7 || !done || write_count != wc0 || dbg.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_end: seen7=%0b last=%0b pulses=%0d ready=%0b required 1 1 0 1",
                     seen7, done, write_count - wc0, dbg.cmd_ready);
        end
    endtask

    task automatic test_cmd_hold();
        int wc0;
        int ac0;
        int early;
        wc0 = write_count;
        ac0 = accept_count;
        early = 0;
        dbg.rsp_ready = 1'b1;
        send_cmd(OP_DUMP, 4'd0, 16'h0000);
        dbg.cmd_op    = OP_WRITE;
        dbg.cmd_addr  = 4'd9;
        dbg.cmd_data  = 16'h1234;
        dbg.cmd_valid = 1'b1;
        for (int c = 0; c < 100 && (accept_count - ac0) < 2; c++) begin
            if (write_count != wc0) early++;
            @(posedge clk); #1;
        end
        dbg.cmd_valid = 1'b0;
        checks++;
        if (early != 0 || accept_count - ac0 != 2) begin
            errors++;
            $display("FAIL hold_accept: accepts=%0d early_writes=%0d required 2 0", accept_count - ac0, early);
        end
        for (int c = 0; c < 4; c++) begin @(posedge clk); #1; end
        dbg.rsp_ready = 1'b0;
        checks++;
        if (accept_count - ac0 != 2 || write_count - wc0 != 1 || rf_mem[9] !== 16'h1234 || dbg.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_write_once: accepts=%0d pulses=%0d reg9=%h ready=%0b required 2 1 1234 1",
                     accept_count - ac0, write_count - wc0, rf_mem[9], dbg.cmd_ready);
        end
        $display("held write accepted once, reg9=%h", rf_mem[9]);
    endtask

    task automatic test_reset_mid_dump();
        bit hit5;
        logic [3:0]  a;
        logic [15:0] d;
        logic        l;
        hit5 = 0;
        dbg.rsp_ready = 1'b1;
        send_cmd(OP_DUMP, 4'd0, 16'h0000);
        for (int c = 0; c < 100 && !hit5; c++) begin
            if (dbg.rsp_valid && dbg.rsp_addr == 4'd5) hit5 = 1;
            else begin @(posedge clk); #1; end
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (!hit5 || dbg.cmd_ready !== 1'b1 || dbg.rsp_valid !== 1'b0 || dbg.rf_write_en !== 1'b0 ||
            dbg.core_hold !== 1'b0 || dbg.rf_read_reg !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid_dump: reached5=%0b ready=%0b valid=%0b wen=%0b hold=%0b ptr=%0d required 1 1 0 0 0 0",
                     hit5, dbg.cmd_ready, dbg.rsp_valid, dbg.rf_write_en, dbg.core_hold, dbg.rf_read_reg);
        end
        #2;
        reset_n = 1'b1;
        dbg.rsp_ready = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (dbg.cmd_ready !== 1'b1 || dbg.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%0b valid=%0b required 1 0", dbg.cmd_ready, dbg.rsp_valid);
        end
        send_cmd(OP_WRITE, 4'd2, 16'h5A5A);
        wait_rsp(a, d, l);
        checks++;
        if (a !== 4'd2 || d !== 16'h5A5A || l !== 1'b1 || rf_mem[2] !== 16'h5A5A) begin
            errors++;
            $display("FAIL post_reset_write: addr=%0d data=%h last=%0b reg2=%h required 2 5a5a 1 5a5a",
                     a, d, l, rf_mem[2]);
        end
        consume();
    endtask

    task automatic test_boundaries();
        logic [3:0]  a;
        logic [15:0] d;
        logic        l;
        dbg.rsp_ready = 1'b0;
        send_cmd(OP_WRITE, 4'd15, 16'hFFFF);
        wait_rsp(a, d, l);
        consume();
        send_cmd(OP_WRITE, 4'd0, 16'h0001);
        wait_rsp(a, d, l);
        consume();
        send_cmd(OP_READ, 4'd15, 16'h0000);
        wait_rsp(a, d, l);
        checks++;
        if (a !== 4'd15 || d !== 16'hFFFF || l !== 1'b1) begin
            errors++;
            $display("FAIL read_reg15: addr=%0d data=%h last=%0b required 15 ffff 1", a, d, l);
        end
        consume();
        send_cmd(OP_READ, 4'd0, 16'h0000);
        wait_rsp(a, d, l);
        checks++;
        if (a !== 4'd0 || d !== 16'h0001 || l !== 1'b1) begin
            errors++;
            $display("FAIL read_reg0: addr=%0d data=%h last=%0b required 0 0001 1", a, d, l);
        end
        consume();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset_n       = 1'b0;
        dbg.cmd_valid = 1'b0;
        dbg.cmd_op    = 2'd0;
        dbg.cmd_addr  = 4'd0;
        dbg.cmd_data  = 16'h0000;
        dbg.rsp_ready = 1'b0;
        #12;
        test_reset();
        #10;
        reset_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_write_read();
        test_fill_dump();
        test_stall();
        test_cmd_hold();
        test_reset_mid_dump();
        test_boundaries();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
